// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: valid/ready sequencer for the calculator's adder datapath.
// Executes ADD, SUB and a W-step shift-add MUL, then range-checks the result
// against LIMIT and holds it until the consumer takes it.
// Optional build macro: SATURATE_EN. When defined, out-of-range results clamp
// to LIMIT-1 (too large) or 0 (negative) instead of wrapping.
module calc_op_sequencer #(
   parameter int unsigned W     = 8,
   parameter int unsigned LIMIT = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W:0]   result,
   output logic         ovf,
   output logic         err,
   output logic         busy
);

   // Accumulator wide enough for a 2W-bit product plus a sign bit for SUB.
   localparam int unsigned AW = 2 * W + 2;
   localparam int unsigned CW = $clog2(W + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, MSTEP, DONE} state_t;

   state_t          state;
   logic [1:0]      op_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [AW-1:0]   acc;
   logic [2*W-1:0]  mcand;
   logic [W-1:0]    mplier;
   logic [CW-1:0]   cnt;

   logic [AW-1:0]   exec_val;
   logic [AW-1:0]   step_val;
   logic [AW-1:0]   fin_val;
   logic            fin_oor;
   logic [W:0]      fin_res;

   // Accepting requests is purely a function of being idle.
   assign start_ready = (state == IDLE);

   // Single-cycle ADD/SUB value; illegal opcodes and MUL produce zero here.
   always_comb begin
      exec_val = '0;
      case (op_q)
         OP_ADD:  exec_val = AW'(a_q) + AW'(b_q);
         OP_SUB:  exec_val = AW'(a_q) - AW'(b_q);
         default: exec_val = '0;
      endcase
   end

   // One shift-add step of the multiplier.
   assign step_val = acc + (mplier[0] ? AW'(mcand) : AW'(0));

   // Range check of the value that is about to land in DONE.
   always_comb begin
      fin_val = (state == MSTEP) ? step_val : exec_val;
      fin_oor = fin_val[AW-1] || (fin_val >= AW'(LIMIT));
`ifdef SATURATE_EN
      if (!fin_oor)
         fin_res = fin_val[W:0];
      else if (fin_val[AW-1])
         fin_res = '0;
      else
         fin_res = (W+1)'(LIMIT - 1);
`else
      fin_res = fin_val[W:0];
`endif
   end

   // Controller FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         result    <= '0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  op_q  <= op;
                  a_q   <= a;
                  b_q   <= b;
                  ovf   <= 1'b0;
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (op_q == OP_MUL) begin
                  acc    <= '0;
                  mcand  <= (2*W)'(a_q);
                  mplier <= b_q;
                  cnt    <= CW'(W);
                  state  <= MSTEP;
               end else begin
                  acc       <= exec_val;
                  result    <= fin_res;
                  ovf       <= fin_oor;
                  err       <= (op_q == OP_ILL);
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            MSTEP: begin
               acc    <= step_val;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  result    <= fin_res;
                  ovf       <= fin_oor;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Testbench for calc_op_sequencer: directed cases plus randomized operations
// checked against an arithmetic reference model. Honours SATURATE_EN.
module tb_calc_op_sequencer;

   localparam int W     = 8;
   localparam int LIMIT = 255;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_valid;
   logic         start_ready;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         res_valid;
   logic         res_ready;
   logic [W:0]   result;
   logic         ovf;
   logic         err;
   logic         busy;

   int n_checks = 0;
   int n_fails  = 0;

   calc_op_sequencer #(.W(W), .LIMIT(LIMIT)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .result     (result),
      .ovf        (ovf),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: true arithmetic result, then range check and wrap/clamp.
   function automatic void model(input int o, input int x, input int y,
                                 output int r, output bit v, output bit e, output int lat);
      int t;
      e   = 1'b0;
      lat = 2;
      case (o)
         0:       t = x + y;
         1:       t = x - y;
         2:       begin t = x * y; lat = W + 2; end
         default: begin t = 0; e = 1'b1; end
      endcase
      v = (t >= LIMIT) || (t < 0);
`ifdef SATURATE_EN
      r = v ? ((t < 0) ? 0 : LIMIT - 1) : t;
`else
      r = t & ((1 << (W + 1)) - 1);
`endif
   endfunction

   // Issue one request, measure latency, check outputs, optionally stall, then drain.
   task automatic run_op(input string tag, input int o, input int x, input int y, input int hold);
      int er, el, lat;
      bit eo, ee;
      model(o, x, y, er, eo, ee, el);
      check({tag, " start_ready"}, 64'(start_ready), 64'd1);
      op = 2'(o); a = W'(x); b = W'(y);
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      lat = 1;
      check({tag, " busy"}, 64'(busy), 64'd1);
      while (!res_valid && lat < 200) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(el));
      check({tag, " result"}, 64'(result), 64'(er));
      check({tag, " ovf"}, 64'(ovf), 64'(eo));
      check({tag, " err"}, 64'(err), 64'(ee));
      check({tag, " start_ready in DONE"}, 64'(start_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, " held result"}, 64'(result), 64'(er));
         check({tag, " held res_valid"}, 64'(res_valid), 64'd1);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({tag, " res_valid drop"}, 64'(res_valid), 64'd0);
      check({tag, " busy drop"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
      op = '0; a = '0; b = '0;
      #1;
      check("reset result", 64'(result), 64'd0);
      check("reset res_valid", 64'(res_valid), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset start_ready", 64'(start_ready), 64'd1);
      #11 rst = 1'b0;
      tick();

      // Directed ADD/SUB/MUL/illegal cases, including range boundaries.
      run_op("add 1+1", 0, 1, 1, 0);
      run_op("add 9+3", 0, 9, 3, 0);
      run_op("add 255+1", 0, 255, 1, 0);
      run_op("add 254+0", 0, 254, 0, 0);
      run_op("sub 9-3", 1, 9, 3, 0);
      run_op("sub 3-9", 1, 3, 9, 0);
      run_op("mul 12x13", 2, 12, 13, 0);
      run_op("mul 16x16", 2, 16, 16, 0);
      run_op("mul 255x255", 2, 255, 255, 0);
      run_op("illegal 5,5", 3, 5, 5, 0);

      // Backpressure with a competing request held on the input.
      op = 2'd0; a = 8'd9; b = 8'd3; start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      tick();
      check("bp res_valid", 64'(res_valid), 64'd1);
      check("bp result", 64'(result), 64'd12);
      op = 2'd1; a = 8'd200; b = 8'd100; start_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp held result", 64'(result), 64'd12);
         check("bp held ovf", 64'(ovf), 64'd0);
         check("bp held err", 64'(err), 64'd0);
         check("bp start_ready", 64'(start_ready), 64'd0);
         check("bp res_valid", 64'(res_valid), 64'd1);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("bp release res_valid", 64'(res_valid), 64'd0);
      check("bp release start_ready", 64'(start_ready), 64'd1);
      tick();
      check("bp next accept busy", 64'(busy), 64'd1);
      check("bp next accept start_ready", 64'(start_ready), 64'd0);
      tick();
      check("bp next res_valid", 64'(res_valid), 64'd1);
      check("bp next result", 64'(result), 64'd100);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      start_valid = 1'b0;
      check("bp next drained", 64'(res_valid), 64'd0);

      // Asynchronous reset in the middle of a multiply; previous result is 100.
      op = 2'd2; a = 8'd12; b = 8'd13; start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      tick();
      tick();
      check("mid-mul busy", 64'(busy), 64'd1);
      #3 rst = 1'b1;
      #1;
      check("async rst result", 64'(result), 64'd0);
      check("async rst ovf", 64'(ovf), 64'd0);
      check("async rst err", 64'(err), 64'd0);
      check("async rst res_valid", 64'(res_valid), 64'd0);
      check("async rst busy", 64'(busy), 64'd0);
      check("async rst start_ready", 64'(start_ready), 64'd1);
      #2 rst = 1'b0;
      tick();
      run_op("post-rst add 1+1", 0, 1, 1, 0);

      // Randomized operations with random consumer stalls.
      for (int i = 0; i < 40; i++) begin
         run_op("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Sequencing controller for the calculator's W+1-bit adder datapath. It accepts one operation request at a time (ADD, SUB, MUL) over a valid/ready handshake and drives the add/accumulate steps. MUL is built as a shift-add loop of W steps. Results are range-checked against LIMIT, and the result is held until the consumer takes it.

Parameters:
W, 8, operand width; result width is W+1.
LIMIT, 255, out-of-range threshold; a true result >= LIMIT (or < 0) is out of range.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-high
start_valid  input  1  request present
start_ready  output  1  controller can accept a request
op  input  2  00 ADD, 01 SUB (a-b), 10 MUL, 11 illegal
a  input  W  operand A, sampled at accept
b  input  W  operand B, sampled at accept
res_valid  output  1  result/flags valid
res_ready  input  1  consumer takes result
result  output  W+1  result value
ovf  output  1  out-of-range flag, valid with res_valid
err  output  1  illegal opcode flag, valid with res_valid
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state, including mid-MUL):
  - state=IDLE; all internal registers cleared.
  - result=0, ovf=0, err=0, res_valid=0, busy=0, start_ready=1 as soon as rst is high.
- States:
  - IDLE: start_ready=1. An accept occurs at a rising edge with start_valid&&start_ready. At accept, capture op, a, b; go to EXEC.
  - EXEC (1 cycle):
    - ADD: acc=a+b in W+2 bits.
    - SUB: acc=a-b, signed.
    - op 11: err=1, acc=0.
    - For ADD, SUB and op 11, go to DONE.
    - MUL: acc=0, mcand=a (2W bits), mplier=b, cnt=W; go to MSTEP.
  - MSTEP (W cycles): each cycle, if mplier[0] then acc+=mcand; then mcand<<=1, mplier>>=1, cnt-=1. Leave for DONE when cnt reaches 0 after the update.
  - DONE: res_valid=1; result, ovf and err are stable. On an edge with res_ready=1, go to IDLE and drop res_valid in the same edge.
- Range check on entering DONE:
  - ovf=1 iff the true result >= LIMIT or < 0.
  - result = low W+1 bits of the true result (two's-complement wrap for a negative SUB result).
- Latency, from the accept edge to the first cycle with res_valid=1:
  - ADD, SUB, illegal: 2 edges.
  - MUL: W+2 edges.
- Request and result rules:
  - start_ready=0 outside IDLE; start_valid is ignored while busy, with no queueing.
  - res_ready while res_valid=0 has no effect.
  - A new request may be accepted on the edge after DONE→IDLE (no same-edge overlap).
  - res_valid stays high indefinitely under backpressure; outputs do not change.
- Flag lifetime: ovf and err are cleared on the next accept. Outputs are registered with no combinational path from inputs, except start_ready = (state==IDLE).

Optional Feature:
SATURATE_EN:
- Defined: when ovf=1, result is clamped instead of wrapped. It becomes LIMIT-1 (254) when the true result >= LIMIT, and 0 when the true result < 0. ovf is still asserted.
- Undefined: wrap behaviour as described in Behaviour.
- Latency is identical in both builds.

Test Plan:
1. Assert rst mid-cycle during MSTEP → immediately state IDLE, result=0, ovf=0, err=0, res_valid=0, busy=0, start_ready=1; a following ADD 1+1 completes normally with result=2.
2. ADD a=1, b=1 → res_valid 2 edges after accept, result=2, ovf=0, err=0; ADD a=9, b=3 → result=12. ADD 255+1 → ovf=1, result=256 without SATURATE_EN, 254 with it. ADD 254+0 → ovf=0 (boundary is LIMIT-1).
3. SUB 9-3 → result=6, ovf=0. SUB 3-9 → ovf=1, result=506 (9'h1FA) without SATURATE_EN, 0 with it.
4. MUL 12×13 → res_valid W+2=10 edges after accept, result=156, ovf=0. MUL 16×16 → ovf=1, result=256 without SATURATE_EN, 254 with it. MUL 255×255 → ovf=1.
5. op=11 with a=5, b=5 → err=1, ovf=0, result=0, latency 2.
6. Backpressure: hold res_ready=0 for 5 cycles after res_valid, with start_valid=1 and new operands → result, ovf and err stable; start_ready=0; no second accept. Then res_ready=1 → IDLE, and the next request is accepted one edge later.
